product_accumulator: RTL

Sequential stage directly downstream of the combinational 4x4 signed/unsigned multiplier. It consumes a stream of 2*DATA_WIDTH-bit products over a valid/ready handshake and sign- or zero-extends each one. It sums a batch of `len` products into an ACC_WIDTH accumulator and presents the total with a sticky overflow flag on an output valid/ready handshake.

---
 rtl/product_acc_pkg.sv | 32 +++
 rtl/product_accumulator.sv | 124 ++++++++++++
 2 files changed

// File: rtl/product_acc_pkg.sv
// Shared types and helpers for the product accumulator that sits behind the
// 4x4 signed/unsigned multiplier.
package product_acc_pkg;

    localparam int DATA_WIDTH    = 4;
    localparam int PROD_WIDTH    = 2 * DATA_WIDTH;
    localparam int MAX_ACC_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Extends the low prod_width bits of product to the full return width; the
    // caller truncates to its own accumulator width.
    function automatic logic [MAX_ACC_WIDTH-1:0] ext_product(
        input logic [MAX_ACC_WIDTH-1:0] product,
        input int unsigned              prod_width,
        input logic                     signed_mode
    );
        logic [MAX_ACC_WIDTH-1:0] mask;
        logic                     sign_bit;
        mask     = (MAX_ACC_WIDTH'(1) << prod_width) - MAX_ACC_WIDTH'(1);
        sign_bit = (product & (MAX_ACC_WIDTH'(1) << (prod_width - 1))) != '0;
        if (signed_mode && sign_bit) begin
            return product | ~mask;
        end
        return product & mask;
    endfunction

endpackage

// File: rtl/product_accumulator.sv
// Sums a batch of multiplier products into a wrapping accumulator and holds the
// total, with a sticky overflow flag, until the downstream accepts it.
module product_accumulator #(
    parameter int DATA_WIDTH  = 4,
    parameter int ACC_WIDTH   = 16,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_signed,
    input  logic [2*DATA_WIDTH-1:0] product,
    input  logic [COUNT_WIDTH-1:0]  len,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_WIDTH-1:0]    acc_out,
    output logic                    out_overflow,
    output logic                    busy
);
    import product_acc_pkg::*;

    localparam int                     PRODW   = 2 * DATA_WIDTH;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                   ovf_q, ovf_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic                   signed_q, signed_d;

    logic                   beat;
    logic                   sign_mode;
    logic [ACC_WIDTH-1:0]   ext_val;
    logic [ACC_WIDTH:0]     sum;
    logic                   add_ovf;
    logic [COUNT_WIDTH-1:0] eff_len;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed by the combinational processes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            remaining_q <= '0;
            signed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            remaining_q <= remaining_d;
            signed_q    <= signed_d;
        end
    end

    assign beat = in_valid && in_ready;

    // The first beat of a batch must use the live in_signed, later beats the captured mode.
    always_comb begin
        sign_mode = (state_q == IDLE) ? in_signed : signed_q;
        ext_val   = ACC_WIDTH'(ext_product(MAX_ACC_WIDTH'(product), PRODW, sign_mode));
        sum       = {1'b0, acc_q} + {1'b0, ext_val};
        if (signed_q) begin
            add_ovf = (acc_q[ACC_WIDTH-1] == ext_val[ACC_WIDTH-1]) &&
                      (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
        end else begin
            add_ovf = sum[ACC_WIDTH];
        end
        eff_len = (len == '0) ? CNT_ONE : len;
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (beat) begin
                    state_d = (eff_len == CNT_ONE) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (beat && remaining_q == CNT_ONE) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        remaining_d = remaining_q;
        signed_d    = signed_q;
        if (beat) begin
            if (state_q == IDLE) begin
                signed_d    = in_signed;
                acc_d       = ext_val;
                ovf_d       = 1'b0;
                remaining_d = eff_len - CNT_ONE;
            end else begin
                acc_d       = sum[ACC_WIDTH-1:0];
                ovf_d       = ovf_q | add_ovf;
                remaining_d = remaining_q - CNT_ONE;
            end
        end
    end

    always_comb begin
        in_ready     = (state_q != HOLD);
        out_valid    = (state_q == HOLD);
        busy         = (state_q != IDLE);
        acc_out      = acc_q;
        out_overflow = ovf_q;
    end

endmodule
